// File: rtl/alu_arbiter_2req.sv
// alu_arbiter_2req
//   Shares one registered 8-function ALU stage between two requesters.
//   Arbitration is round-robin, and only one operation is in flight at a time.
//   The result is held on a single registered port, tagged with its owner,
//   until the consumer takes it.
//
//   Optional build macro: ALU_ARB_FLAGS_EN
//     When defined, the output_flag_zero and output_flag_carry ports are added.
//     Both flags are registered together with output_result.
//
// Ports
//   input_clk              clock; all state changes on the rising edge
//   input_rst              synchronous, active-high reset
//   input_reqN_valid       requester N has an operation pending (N = 0, 1)
//   output_reqN_ready      requester N's operation is accepted this cycle
//   input_reqN_mode        3-bit ALU function select
//   input_reqN_a/_b        operands
//   output_result_valid    a result is held on the result port
//   input_result_ready     the consumer takes the result
//   output_result          ALU result
//   output_result_owner    requester that issued the result (0 or 1)
//   output_flag_zero       (ALU_ARB_FLAGS_EN) result == 0
//   output_flag_carry      (ALU_ARB_FLAGS_EN) add carry-out / sub borrow
module alu_arbiter_2req #(
    parameter int WIDTH     = 8,
    parameter int TIE_FIRST = 0
) (
    input  logic             input_clk,
    input  logic             input_rst,
    input  logic             input_req0_valid,
    output logic             output_req0_ready,
    input  logic [2:0]       input_req0_mode,
    input  logic [WIDTH-1:0] input_req0_a,
    input  logic [WIDTH-1:0] input_req0_b,
    input  logic             input_req1_valid,
    output logic             output_req1_ready,
    input  logic [2:0]       input_req1_mode,
    input  logic [WIDTH-1:0] input_req1_a,
    input  logic [WIDTH-1:0] input_req1_b,
    output logic             output_result_valid,
    input  logic             input_result_ready,
    output logic [WIDTH-1:0] output_result,
`ifdef ALU_ARB_FLAGS_EN
    output logic             output_flag_zero,
    output logic             output_flag_carry,
`endif
    output logic             output_result_owner
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

    // last_grant resets to the opposite of TIE_FIRST.
    // This makes the first tie after reset go to TIE_FIRST.
    localparam logic TIE_BIT = (TIE_FIRST != 0);

    state_t           state;
    logic             last_grant;
    logic             grant_valid;
    logic             grant_sel;

    logic [2:0]       op_mode_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             op_owner_q;

    logic [WIDTH-1:0] alu_res;

    // Grant is decided combinationally, and only while IDLE.
    // NOTE: every signal driven in always_comb gets a default first.
    // Without the default, a missed branch would infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (state == ST_IDLE) begin
            case ({input_req1_valid, input_req0_valid})
                2'b01:   begin grant_valid = 1'b1; grant_sel = 1'b0;        end
                2'b10:   begin grant_valid = 1'b1; grant_sel = 1'b1;        end
                2'b11:   begin grant_valid = 1'b1; grant_sel = ~last_grant; end
                default: begin grant_valid = 1'b0; grant_sel = 1'b0;        end
            endcase
        end
    end

    // Both readies are held low in the reset cycle, even though state is IDLE.
    assign output_req0_ready = grant_valid && !grant_sel && !input_rst;
    assign output_req1_ready = grant_valid &&  grant_sel && !input_rst;

    // The ALU is evaluated from the latched operands.
    // Its output is registered during EXEC.
    always_comb begin
        alu_res = '0;
        case (op_mode_q)
            3'b000: alu_res = op_a_q + op_b_q;
            3'b001: alu_res = op_a_q - op_b_q;
            3'b010: alu_res = WIDTH'(op_a_q == '0);
            3'b011: alu_res = op_a_q & op_b_q;
            3'b100: alu_res = op_a_q | op_b_q;
            3'b101: alu_res = op_a_q ^ op_b_q;
            3'b110: alu_res = WIDTH'(op_a_q < op_b_q);
            3'b111: alu_res = WIDTH'(op_a_q == op_b_q);
        endcase
    end

`ifdef ALU_ARB_FLAGS_EN
    logic [WIDTH:0] add_full;
    logic           carry_next;

    assign add_full = {1'b0, op_a_q} + {1'b0, op_b_q};

    always_comb begin
        carry_next = 1'b0;
        if (op_mode_q == 3'b000) begin
            carry_next = add_full[WIDTH];
        end else if (op_mode_q == 3'b001) begin
            carry_next = (op_a_q < op_b_q);
        end
    end
`endif

    // Operand store.
    // It is written only on an accepting edge and read only after one.
    // NOTE: this datapath storage is deliberately left out of reset.
    // Its contents are meaningless until an accept overwrites them.
    always_ff @(posedge input_clk) begin
        if (!input_rst && grant_valid) begin
            op_mode_q  <= grant_sel ? input_req1_mode : input_req0_mode;
            op_a_q     <= grant_sel ? input_req1_a    : input_req0_a;
            op_b_q     <= grant_sel ? input_req1_b    : input_req0_b;
            op_owner_q <= grant_sel;
        end
    end

    // Control FSM and the registered result port.
    // NOTE: sequential state uses non-blocking assignments only.
    // All registers then update together from pre-edge values.
    always_ff @(posedge input_clk) begin
        if (input_rst) begin
            state               <= ST_IDLE;
            last_grant          <= ~TIE_BIT;
            output_result_valid <= 1'b0;
            output_result       <= '0;
            output_result_owner <= 1'b0;
`ifdef ALU_ARB_FLAGS_EN
            output_flag_zero    <= 1'b0;
            output_flag_carry   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant_sel;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    output_result       <= alu_res;
                    output_result_owner <= op_owner_q;
                    output_result_valid <= 1'b1;
`ifdef ALU_ARB_FLAGS_EN
                    output_flag_zero    <= (alu_res == '0);
                    output_flag_carry   <= carry_next;
`endif
                    state               <= ST_DONE;
                end
                ST_DONE: begin
                    if (input_result_ready) begin
                        output_result_valid <= 1'b0;
                        state               <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter_2req.sv
// Directed testbench for alu_arbiter_2req (WIDTH = 8, TIE_FIRST = 0).
// Expected values are hand-computed constants.
// When ALU_ARB_FLAGS_EN is defined, the flag ports are checked as well.
module tb_alu_arbiter_2req;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0_valid, r1_valid;
    logic       r0_ready, r1_ready;
    logic [2:0] r0_mode, r1_mode;
    logic [7:0] r0_a, r0_b, r1_a, r1_b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res;
    logic       res_owner;
`ifdef ALU_ARB_FLAGS_EN
    logic       flag_zero, flag_carry;
`endif

    int total = 0;
    int bad   = 0;

    alu_arbiter_2req #(.WIDTH(8), .TIE_FIRST(0)) dut (
        .input_clk           (clk),
        .input_rst           (rst),
        .input_req0_valid    (r0_valid),
        .output_req0_ready   (r0_ready),
        .input_req0_mode     (r0_mode),
        .input_req0_a        (r0_a),
        .input_req0_b        (r0_b),
        .input_req1_valid    (r1_valid),
        .output_req1_ready   (r1_ready),
        .input_req1_mode     (r1_mode),
        .input_req1_a        (r1_a),
        .input_req1_b        (r1_b),
        .output_result_valid (res_valid),
        .input_result_ready  (res_ready),
        .output_result       (res),
`ifdef ALU_ARB_FLAGS_EN
        .output_flag_zero    (flag_zero),
        .output_flag_carry   (flag_carry),
`endif
        .output_result_owner (res_owner)
    );

    always #5 clk = ~clk;

    // Inputs are driven, and outputs sampled, 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic exp_z, input logic exp_c);
`ifdef ALU_ARB_FLAGS_EN
        chk1({tag, "_zero"},  flag_zero,  exp_z);
        chk1({tag, "_carry"}, flag_carry, exp_c);
`else
        if (exp_z === 1'bx || exp_c === 1'bx) $display("note: %s", tag);
`endif
    endtask

    // One complete transaction from a single requester.
    // It is called while the DUT is IDLE, with both valids low.
    task automatic run_op(input string tag, input logic who, input logic [2:0] mode,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_r, input logic exp_c);
        if (!who) begin
            r0_valid = 1'b1; r0_mode = mode; r0_a = a; r0_b = b;
        end else begin
            r1_valid = 1'b1; r1_mode = mode; r1_a = a; r1_b = b;
        end
        #1;
        chk1({tag, "_rdy0"}, r0_ready, !who);
        chk1({tag, "_rdy1"}, r1_ready, who);
        tick();                               // accept edge -> EXEC
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        chk1({tag, "_exec_valid"}, res_valid, 1'b0);
        tick();                               // EXEC -> DONE
        chk1({tag, "_valid"}, res_valid, 1'b1);
        chk8({tag, "_result"}, res, exp_r);
        chk1({tag, "_owner"}, res_owner, who);
        chk_flags(tag, exp_r == 8'h00, exp_c);
        res_ready = 1'b1;
        tick();                               // DONE -> IDLE
        res_ready = 1'b0;
        chk1({tag, "_idle_valid"}, res_valid, 1'b0);
    endtask

    initial begin
        logic exp_g;

        rst = 1'b1;
        r0_valid = 1'b0; r0_mode = 3'b000; r0_a = 8'h00; r0_b = 8'h00;
        r1_valid = 1'b0; r1_mode = 3'b000; r1_a = 8'h00; r1_b = 8'h00;
        res_ready = 1'b0;
        tick();
        tick();

        // Reset state. A request during reset must not be made ready.
        r0_valid = 1'b1;
        #1;
        chk1("rst_rdy0", r0_ready, 1'b0);
        chk1("rst_rdy1", r1_ready, 1'b0);
        chk1("rst_valid", res_valid, 1'b0);
        chk8("rst_result", res, 8'h00);
        chk1("rst_owner", res_owner, 1'b0);
        r0_valid = 1'b0;
        rst = 1'b0;

        // req0 alone: 0xF0 + 0x20 = 0x110, so the result is 0x10 with carry 1.
        run_op("add0", 1'b0, 3'b000, 8'hF0, 8'h20, 8'h10, 1'b1);

        // req1: unsigned 3 < 4 gives 1.
        // The result is then held for 5 cycles while both sides request.
        r1_valid = 1'b1; r1_mode = 3'b110; r1_a = 8'h03; r1_b = 8'h04;
        #1;
        chk1("lt_rdy1", r1_ready, 1'b1);
        chk1("lt_rdy0", r0_ready, 1'b0);
        tick();
        r1_valid = 1'b0;
        tick();
        chk1("lt_valid", res_valid, 1'b1);
        chk8("lt_result", res, 8'h01);
        chk1("lt_owner", res_owner, 1'b1);
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("hold_rdy0", r0_ready, 1'b0);
            chk1("hold_rdy1", r1_ready, 1'b0);
            chk1("hold_valid", res_valid, 1'b1);
            chk8("hold_result", res, 8'h01);
            tick();
        end
        res_ready = 1'b1;
        tick();                               // DONE -> IDLE
        // Back in IDLE with last_grant = 1, so the tie goes to req0.
        chk1("release_valid", res_valid, 1'b0);
        chk1("release_rdy0", r0_ready, 1'b1);
        chk1("release_rdy1", r1_ready, 1'b0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;

        // Continuous requests from both sides, with result ready tied high.
        // Subtract: req0 5-7 = 0xFE (borrow); req1 9-9 = 0x00 (zero).
        r0_mode = 3'b001; r0_a = 8'h05; r0_b = 8'h07;
        r1_mode = 3'b001; r1_a = 8'h09; r1_b = 8'h09;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        exp_g = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("alt_rdy0", r0_ready, !exp_g);
            chk1("alt_rdy1", r1_ready, exp_g);
            tick();                           // accept -> EXEC
            chk1("alt_exec_valid", res_valid, 1'b0);
            chk1("alt_exec_rdy0", r0_ready, 1'b0);
            chk1("alt_exec_rdy1", r1_ready, 1'b0);
            tick();                           // EXEC -> DONE
            chk1("alt_valid", res_valid, 1'b1);
            chk1("alt_owner", res_owner, exp_g);
            chk8("alt_result", res, exp_g ? 8'h00 : 8'hFE);
            chk_flags("alt", exp_g, !exp_g);
            tick();                           // DONE -> IDLE
            exp_g = ~exp_g;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        res_ready = 1'b0;

        // Mode sweep on req1. It is granted every time while alone.
        run_op("not0",  1'b1, 3'b010, 8'h00, 8'h00, 8'h01, 1'b0);
        run_op("not55", 1'b1, 3'b010, 8'h55, 8'h00, 8'h00, 1'b0);
        run_op("and",   1'b1, 3'b011, 8'hCC, 8'hAA, 8'h88, 1'b0);
        run_op("or",    1'b1, 3'b100, 8'hCC, 8'hAA, 8'hEE, 1'b0);
        run_op("xor",   1'b1, 3'b101, 8'hCC, 8'hAA, 8'h66, 1'b0);
        run_op("eq",    1'b1, 3'b111, 8'h3C, 8'h3C, 8'h01, 1'b0);

        // Payload changed after acceptance: 0x01 + 0x02 must give 3, not 0x01.
        r0_valid = 1'b1; r0_mode = 3'b000; r0_a = 8'h01; r0_b = 8'h02;
        #1;
        chk1("pay_rdy0", r0_ready, 1'b1);
        tick();
        r0_valid = 1'b0;
        r0_a = 8'hFF;
        tick();
        chk8("pay_result", res, 8'h03);
        chk1("pay_owner", res_owner, 1'b0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Reset in EXEC discards the pending op (0x10 + 0x20) from req1.
        r1_valid = 1'b1; r1_mode = 3'b000; r1_a = 8'h10; r1_b = 8'h20;
        #1;
        chk1("rx_rdy1", r1_ready, 1'b1);
        tick();                               // accept -> EXEC
        r1_valid = 1'b0;
        rst = 1'b1;
        tick();
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        #1;
        chk1("rx_valid", res_valid, 1'b0);
        chk8("rx_result", res, 8'h00);
        chk1("rx_owner", res_owner, 1'b0);
        chk1("rx_rdy0", r0_ready, 1'b0);
        chk1("rx_rdy1", r1_ready, 1'b0);
        chk_flags("rx", 1'b0, 1'b0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        chk1("rx_no_result", res_valid, 1'b0);
        chk8("rx_no_result_val", res, 8'h00);

        // The first tie after reset goes to TIE_FIRST (req0).
        r0_mode = 3'b000; r0_a = 8'h01; r0_b = 8'h01;
        r1_mode = 3'b000; r1_a = 8'h02; r1_b = 8'h02;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        #1;
        chk1("tie_rdy0", r0_ready, 1'b1);
        chk1("tie_rdy1", r1_ready, 1'b0);
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();
        chk1("tie_valid", res_valid, 1'b1);
        chk8("tie_result", res, 8'h02);
        chk1("tie_owner", res_owner, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
